// File: rtl/score_bcd_gen_pkg.sv
// Shared constants and types for the score-to-BCD generator.
package score_pkg;

  localparam int unsigned SCORE_W_DEF   = 10;
  localparam int unsigned NDIGITS_DEF   = 3;
  localparam int unsigned SCORE_MAX_DEF = 999;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} score_state_t;

  typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/score_bcd_gen_if.sv
// Score control inputs and committed-digit outputs of score_bcd_gen.
interface score_bcd_gen_if
  import score_pkg::*;
#(
  parameter int unsigned SCORE_W = SCORE_W_DEF,
  parameter int unsigned NDIGITS = NDIGITS_DEF
);

  logic                   vga_vs;
  logic                   score_inc;
  logic                   score_clr;
  logic                   wr_en;
  logic [SCORE_W-1:0]     wr_data;
  logic [SCORE_W-1:0]     score_bin;
  logic [4*NDIGITS-1:0]   digits_bcd;
  logic [NDIGITS-1:0]     digit_blank;
  logic                   digits_valid;
  logic                   busy;
  logic                   commit;

  modport master (
    output vga_vs, score_inc, score_clr, wr_en, wr_data,
    input  score_bin, digits_bcd, digit_blank, digits_valid, busy, commit
  );

  modport slave (
    input  vga_vs, score_inc, score_clr, wr_en, wr_data,
    output score_bin, digits_bcd, digit_blank, digits_valid, busy, commit
  );

endinterface

// File: rtl/score_bcd_gen_bcd_add3_nibble.sv
// Double-dabble digit adjust: nibbles of 5 or more get +3 before the shift.
module bcd_add3_nibble
  import score_pkg::*;
(
  input  bcd_digit_t din,
  output bcd_digit_t dout
);

  always_comb begin
    dout = (din >= 4'd5) ? din + 4'd3 : din;
  end

endmodule

// File: rtl/score_bcd_gen.sv
// Saturating score counter with once-per-frame double-dabble BCD conversion.
// Optional SCORE_LEADING_ZERO_BLANK_EN enables the leading-zero blank mask.
module score_bcd_gen
  import score_pkg::*;
#(
  parameter int unsigned SCORE_W   = SCORE_W_DEF,
  parameter int unsigned NDIGITS   = NDIGITS_DEF,
  parameter int unsigned SCORE_MAX = SCORE_MAX_DEF
)(
  input  logic               clk,
  input  logic               reset,
  score_bcd_gen_if.slave     bus
);

  localparam int unsigned     BCD_W = 4 * NDIGITS;
  localparam int unsigned     CNT_W = $clog2(SCORE_W);
  localparam logic [SCORE_W-1:0] MAX_V = SCORE_W'(SCORE_MAX);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(SCORE_W - 1);

  score_state_t          state_q, state_d;
  logic [SCORE_W-1:0]    score_q;
  logic [SCORE_W-1:0]    snap_q, snap_d;
  logic [BCD_W-1:0]      bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pending_q, pending_d;
  logic [BCD_W-1:0]      digits_q;
  logic                  valid_q;
  logic                  vs_q;
  logic                  trigger;
  logic                  load;
  logic [BCD_W+SCORE_W-1:0] dd_shift;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_q <= '0;
    end else if (bus.score_clr) begin
      score_q <= '0;
    end else if (bus.wr_en) begin
      score_q <= (bus.wr_data > MAX_V) ? MAX_V : bus.wr_data;
    end else if (bus.score_inc && (score_q < MAX_V)) begin
      score_q <= score_q + SCORE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) vs_q <= 1'b1;
    else       vs_q <= bus.vga_vs;
  end

  assign trigger = vs_q & ~bus.vga_vs;

  for (genvar g = 0; g < NDIGITS; g++) begin : g_adj
    bcd_add3_nibble u_adj (
      .din  (bcd_q[4*g +: 4]),
      .dout (bcd_adj[4*g +: 4])
    );
  end

  // Adjusted digits and snapshot shift together; the top adjusted bit falls off.
  assign dd_shift = {bcd_adj, snap_q} << 1;

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    load      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trigger || pending_q) begin
          load    = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        bcd_d  = dd_shift[BCD_W+SCORE_W-1:SCORE_W];
        snap_d = dd_shift[SCORE_W-1:0];
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        if (pending_q) begin
          load    = 1'b1;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      snap_d    = score_q;
      bcd_d     = '0;
      cnt_d     = '0;
      pending_d = 1'b0;
    end
    // A trigger while a conversion is in flight is remembered, even on a reload cycle.
    if (trigger && (state_q != S_IDLE)) pending_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      snap_q    <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      digits_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      if (state_q == S_COMMIT) begin
        digits_q <= bcd_q;
        valid_q  <= 1'b1;
      end
    end
  end

`ifdef SCORE_LEADING_ZERO_BLANK_EN
  logic [NDIGITS-1:0] blank_d, blank_q;
  logic               higher_zero;

  always_comb begin
    blank_d     = '0;
    higher_zero = 1'b1;
    for (int unsigned i = NDIGITS - 1; i >= 1; i--) begin
      higher_zero = higher_zero && (bcd_q[4*i +: 4] == 4'd0);
      blank_d[i]  = higher_zero;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    blank_q <= '0;
    else if (state_q == S_COMMIT) blank_q <= blank_d;
  end

  assign bus.digit_blank = blank_q;
`else
  assign bus.digit_blank = '0;
`endif

  assign bus.score_bin    = score_q;
  assign bus.digits_bcd   = digits_q;
  assign bus.digits_valid = valid_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.commit       = (state_q == S_COMMIT);

endmodule

// File: tb/tb_score_bcd_gen.sv
// Directed self-checking bench for score_bcd_gen (default parameters).
module tb_score_bcd_gen;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

`ifdef SCORE_LEADING_ZERO_BLANK_EN
  localparam logic [2:0] BLANK_000 = 3'b110;
  localparam logic [2:0] BLANK_0XX = 3'b100;
`else
  localparam logic [2:0] BLANK_000 = 3'b000;
  localparam logic [2:0] BLANK_0XX = 3'b000;
`endif

  score_bcd_gen_if #(.SCORE_W(10), .NDIGITS(3)) bus ();

  score_bcd_gen #(.SCORE_W(10), .NDIGITS(3), .SCORE_MAX(999)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic write_score(input logic [9:0] v);
    bus.wr_en   = 1'b1;
    bus.wr_data = v;
    cycle();
    bus.wr_en   = 1'b0;
  endtask

  // Drives one vga_vs falling edge; lat is the cycle count from the trigger
  // cycle to the commit pulse, or -1 if no commit appeared within 20 cycles.
  task automatic frame(output int lat);
    bus.vga_vs = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      cycle();
      if (k == 3) bus.vga_vs = 1'b1;
      if (bus.commit) begin
        lat = k;
        break;
      end
    end
    bus.vga_vs = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.vga_vs = 1'b1; bus.score_inc = 1'b0; bus.score_clr = 1'b0;
    bus.wr_en = 1'b0; bus.wr_data = '0;
    cycle(); cycle();
    reset = 1'b0;
    cycle();
    checks++;
    if (bus.score_bin !== 10'd0 || bus.digits_bcd !== 12'h000 || bus.digit_blank !== 3'b000 ||
        bus.digits_valid !== 1'b0 || bus.busy !== 1'b0 || bus.commit !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: score=%0d digits=%h blank=%b valid=%b busy=%b commit=%b, required all zero",
               bus.score_bin, bus.digits_bcd, bus.digit_blank, bus.digits_valid, bus.busy, bus.commit);
    end
  endtask

  task automatic test_first_frame();
    int lat;
    frame(lat);
    checks++;
    if (lat !== 11) begin errors++; $display("FAIL first_latency: got %0d required 11", lat); end
    cycle();
    checks++;
    if (bus.digits_bcd !== 12'h000) begin errors++; $display("FAIL first_digits: got %h required 000", bus.digits_bcd); end
    checks++;
    if (bus.digits_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b required 1", bus.digits_valid); end
    checks++;
    if (bus.digit_blank !== BLANK_000) begin errors++; $display("FAIL first_blank: got %b required %b", bus.digit_blank, BLANK_000); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL first_idle_busy: got %b required 0", bus.busy); end
  endtask

  task automatic test_write_742();
    int lat;
    write_score(10'd742);
    checks++;
    if (bus.score_bin !== 10'd742) begin errors++; $display("FAIL wr_742: got %0d required 742", bus.score_bin); end
    frame(lat);
    checks++;
    if (lat !== 11) begin errors++; $display("FAIL latency_742: got %0d required 11", lat); end
    cycle();
    checks++;
    if (bus.digits_bcd !== 12'h742) begin errors++; $display("FAIL digits_742: got %h required 742", bus.digits_bcd); end
    checks++;
    if (bus.digit_blank !== 3'b000) begin errors++; $display("FAIL blank_742: got %b required 000", bus.digit_blank); end
  endtask

  task automatic test_saturation();
    int lat;
    write_score(10'd1023);
    checks++;
    if (bus.score_bin !== 10'd999) begin errors++; $display("FAIL wr_clamp: got %0d required 999", bus.score_bin); end
    for (int i = 0; i < 5; i++) begin
      bus.score_inc = 1'b1; cycle();
      bus.score_inc = 1'b0; cycle();
    end
    checks++;
    if (bus.score_bin !== 10'd999) begin errors++; $display("FAIL inc_saturate: got %0d required 999", bus.score_bin); end
    frame(lat);
    cycle();
    checks++;
    if (bus.digits_bcd !== 12'h999) begin errors++; $display("FAIL digits_999: got %h required 999", bus.digits_bcd); end
  endtask

  task automatic test_snapshot();
    int lat;
    write_score(10'd57);
    bus.vga_vs = 1'b0;
    cycle();
    bus.score_inc = 1'b1;
    cycle();
    bus.score_inc = 1'b0;
    bus.vga_vs = 1'b1;
    lat = -1;
    for (int k = 3; k <= 20; k++) begin
      cycle();
      if (bus.commit) begin lat = k; break; end
    end
    checks++;
    if (lat !== 11) begin errors++; $display("FAIL snap_latency: got %0d required 11", lat); end
    checks++;
    if (bus.score_bin !== 10'd58) begin errors++; $display("FAIL snap_live_score: got %0d required 58", bus.score_bin); end
    cycle();
    checks++;
    if (bus.digits_bcd !== 12'h057) begin errors++; $display("FAIL snap_digits: got %h required 057", bus.digits_bcd); end
    checks++;
    if (bus.digit_blank !== BLANK_0XX) begin errors++; $display("FAIL snap_blank: got %b required %b", bus.digit_blank, BLANK_0XX); end
    frame(lat);
    cycle();
    checks++;
    if (bus.digits_bcd !== 12'h058) begin errors++; $display("FAIL next_frame_digits: got %h required 058", bus.digits_bcd); end
  endtask

  task automatic test_back_to_back();
    int c1, c2, ncommit, idle_cycles;
    write_score(10'd123);
    c1 = -1; c2 = -1; ncommit = 0; idle_cycles = 0;
    bus.vga_vs = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      cycle();
      if (k == 1) bus.vga_vs = 1'b1;
      if (k == 3) bus.vga_vs = 1'b0;
      if (k == 5) begin bus.vga_vs = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 10'd456; end
      if (k == 6) bus.wr_en = 1'b0;
      if (bus.commit) begin
        ncommit++;
        if (c1 < 0) c1 = k; else if (c2 < 0) c2 = k;
      end
      if (k <= 22 && bus.busy !== 1'b1) idle_cycles++;
      if (k == 12) begin
        checks++;
        if (bus.digits_bcd !== 12'h123) begin errors++; $display("FAIL b2b_first_digits: got %h required 123", bus.digits_bcd); end
      end
      if (k == 23) begin
        checks++;
        if (bus.digits_bcd !== 12'h456) begin errors++; $display("FAIL b2b_second_digits: got %h required 456", bus.digits_bcd); end
      end
    end
    checks++;
    if (c1 !== 11) begin errors++; $display("FAIL b2b_first_commit: got cycle %0d required 11", c1); end
    checks++;
    if (c2 - c1 !== 11) begin errors++; $display("FAIL b2b_spacing: got %0d required 11", c2 - c1); end
    checks++;
    if (ncommit !== 2) begin errors++; $display("FAIL b2b_commit_count: got %0d required 2", ncommit); end
    checks++;
    if (idle_cycles !== 0) begin errors++; $display("FAIL b2b_no_idle: got %0d idle cycles required 0", idle_cycles); end
  endtask

  task automatic test_priority();
    write_score(10'd5);
    bus.score_clr = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 10'd300; bus.score_inc = 1'b1;
    cycle();
    bus.score_clr = 1'b0; bus.wr_en = 1'b0; bus.score_inc = 1'b0;
    checks++;
    if (bus.score_bin !== 10'd0) begin errors++; $display("FAIL prio_clr: got %0d required 0", bus.score_bin); end
    bus.wr_en = 1'b1; bus.wr_data = 10'd300; bus.score_inc = 1'b1;
    cycle();
    bus.wr_en = 1'b0; bus.score_inc = 1'b0;
    checks++;
    if (bus.score_bin !== 10'd300) begin errors++; $display("FAIL prio_wr: got %0d required 300", bus.score_bin); end
    bus.score_inc = 1'b1;
    cycle();
    bus.score_inc = 1'b0;
    checks++;
    if (bus.score_bin !== 10'd301) begin errors++; $display("FAIL inc: got %0d required 301", bus.score_bin); end
  endtask

  task automatic test_reset_mid();
    bus.vga_vs = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      if (k == 1) bus.vga_vs = 1'b1;
    end
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b required 1", bus.busy); end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.digits_bcd !== 12'h000 || bus.digits_valid !== 1'b0 || bus.score_bin !== 10'd0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b digits=%h valid=%b score=%0d required 0/000/0/0",
               bus.busy, bus.digits_bcd, bus.digits_valid, bus.score_bin);
    end
    cycle(); cycle();
    reset = 1'b0;
    cycle(); cycle();
    checks++;
    if (bus.busy !== 1'b0 || bus.commit !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: busy=%b commit=%b required 0/0", bus.busy, bus.commit);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_first_frame();
    test_write_742();
    test_saturation();
    test_snapshot();
    test_back_to_back();
    test_priority();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
